// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the MIPS pipeline.
// A one-entry buffer absorbs decode stalls; redirects during an outstanding request drain through DISCARD.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        if_id_valid,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc_plus4
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      HOLD    = 2'd2,
      DISCARD = 2'd3
   } state_t;

   state_t      state_reg, state_next;
   logic [31:0] pc_reg, pc_next;
   logic [31:0] tgt_reg, tgt_next;
   logic        buf_valid_reg, buf_valid_next;
   logic [31:0] buf_instr_reg, buf_instr_next;
   logic [31:0] buf_pc_reg, buf_pc_next;
   logic        ifid_valid_reg, ifid_valid_next;
   logic [31:0] ifid_instr_reg, ifid_instr_next;
   logic [31:0] ifid_pc_reg, ifid_pc_next;
   logic [31:0] ifid_pc4_reg, ifid_pc4_next;

   logic [31:0] pc_plus4;
   assign pc_plus4 = pc_reg + 32'd4;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         pc_reg         <= RESET_PC;
         tgt_reg        <= 32'h0;
         buf_valid_reg  <= 1'b0;
         buf_instr_reg  <= 32'h0;
         buf_pc_reg     <= 32'h0;
         ifid_valid_reg <= 1'b0;
         ifid_instr_reg <= 32'h0;
         ifid_pc_reg    <= 32'h0;
         ifid_pc4_reg   <= 32'h0;
      end else begin
         state_reg      <= state_next;
         pc_reg         <= pc_next;
         tgt_reg        <= tgt_next;
         buf_valid_reg  <= buf_valid_next;
         buf_instr_reg  <= buf_instr_next;
         buf_pc_reg     <= buf_pc_next;
         ifid_valid_reg <= ifid_valid_next;
         ifid_instr_reg <= ifid_instr_next;
         ifid_pc_reg    <= ifid_pc_next;
         ifid_pc4_reg   <= ifid_pc4_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      pc_next         = pc_reg;
      tgt_next        = tgt_reg;
      buf_valid_next  = buf_valid_reg;
      buf_instr_next  = buf_instr_reg;
      buf_pc_next     = buf_pc_reg;
      ifid_valid_next = ifid_valid_reg;
      ifid_instr_next = ifid_instr_reg;
      ifid_pc_next    = ifid_pc_reg;
      ifid_pc4_next   = ifid_pc4_reg;

      case (state_reg)
         IDLE: begin
            state_next = FETCH;
            if (redirect_i) pc_next = redirect_pc_i;
         end
         FETCH: begin
            if (redirect_i) begin
               // An outstanding request cannot be withdrawn, so park the target until it completes
               if (imem_ack) begin
                  pc_next    = redirect_pc_i;
                  state_next = FETCH;
               end else begin
                  tgt_next   = redirect_pc_i;
                  state_next = DISCARD;
               end
            end else if (imem_ack && !stall_i) begin
               ifid_valid_next = 1'b1;
               ifid_instr_next = imem_rdata;
               ifid_pc_next    = pc_reg;
               ifid_pc4_next   = pc_plus4;
               pc_next         = pc_plus4;
            end else if (imem_ack) begin
               buf_valid_next = 1'b1;
               buf_instr_next = imem_rdata;
               buf_pc_next    = pc_reg;
               pc_next        = pc_plus4;
               state_next     = HOLD;
            end else if (!stall_i) begin
               ifid_valid_next = 1'b0;
            end
         end
         HOLD: begin
            if (redirect_i) begin
               pc_next    = redirect_pc_i;
               state_next = FETCH;
            end else if (!stall_i) begin
               ifid_valid_next = buf_valid_reg;
               ifid_instr_next = buf_instr_reg;
               ifid_pc_next    = buf_pc_reg;
               ifid_pc4_next   = buf_pc_reg + 32'd4;
               buf_valid_next  = 1'b0;
               state_next      = FETCH;
            end
         end
         DISCARD: begin
            ifid_valid_next = 1'b0;
            if (redirect_i) tgt_next = redirect_pc_i;
            if (imem_ack) begin
               pc_next    = redirect_i ? redirect_pc_i : tgt_reg;
               state_next = FETCH;
            end
         end
         default: state_next = IDLE;
      endcase

      if (redirect_i) begin
         ifid_valid_next = 1'b0;
         buf_valid_next  = 1'b0;
      end
   end

   assign imem_req       = (state_reg == FETCH) || (state_reg == DISCARD);
   assign imem_addr      = pc_reg;
   assign if_id_valid    = ifid_valid_reg;
   assign if_id_instr    = ifid_instr_reg;
   assign if_id_pc       = ifid_pc_reg;
   assign if_id_pc_plus4 = ifid_pc4_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage; a second instance exercises PC wrap-around.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ack = 1'b0;
   logic        stall = 1'b0;
   logic        redir = 1'b0;
   logic [31:0] rpc = 32'h0;

   logic        req0, req1;
   logic [31:0] addr0, addr1, rdata0, rdata1;
   logic        v0, v1;
   logic [31:0] instr0, instr1, pc0, pc1, pc4_0, pc4_1;

   int total_cnt = 0;
   int pass_cnt  = 0;

   always #5 clk = ~clk;

   // Zero-wait memory model: data is a fixed function of the address
   assign rdata0 = addr0 ^ 32'hA5A5_0000;
   assign rdata1 = addr1 ^ 32'hA5A5_0000;

   fetch_stage dut0 (
      .clk(clk), .rst_n(rst_n), .imem_req(req0), .imem_addr(addr0),
      .imem_ack(ack), .imem_rdata(rdata0), .stall_i(stall),
      .redirect_i(redir), .redirect_pc_i(rpc), .if_id_valid(v0),
      .if_id_instr(instr0), .if_id_pc(pc0), .if_id_pc_plus4(pc4_0)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
      .clk(clk), .rst_n(rst_n), .imem_req(req1), .imem_addr(addr1),
      .imem_ack(ack), .imem_rdata(rdata1), .stall_i(stall),
      .redirect_i(redir), .redirect_pc_i(rpc), .if_id_valid(v1),
      .if_id_instr(instr1), .if_id_pc(pc1), .if_id_pc_plus4(pc4_1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   typedef struct packed {
      logic        ack;
      logic        stall;
      logic        redir;
      logic [31:0] rpc;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
   } vec_t;

   typedef struct packed {
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_pc4;
   } wrap_t;

   vec_t  vecs[21];
   wrap_t wvecs[4];

   initial begin
      // ack stall redir rpc | req addr valid if_id_pc
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h000, 1'b0, 32'h000};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h004, 1'b1, 32'h000};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h008, 1'b1, 32'h004};
      vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h00C, 1'b1, 32'h004};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h00C, 1'b1, 32'h004};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h00C, 1'b1, 32'h004};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h00C, 1'b1, 32'h008};
      vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h010, 1'b1, 32'h00C};
      vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h014, 1'b1, 32'h010};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 32'h014, 1'b0, 32'h000};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h014, 1'b0, 32'h000};
      vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h000};
      vecs[12] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h100};
      vecs[13] = '{1'b1, 1'b1, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h000};
      vecs[14] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h204, 1'b1, 32'h200};
      vecs[15] = '{1'b0, 1'b0, 1'b1, 32'h300, 1'b1, 32'h204, 1'b0, 32'h000};
      vecs[16] = '{1'b1, 1'b0, 1'b1, 32'h400, 1'b1, 32'h400, 1'b0, 32'h000};
      vecs[17] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h404, 1'b1, 32'h400};
      vecs[18] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h404, 1'b0, 32'h000};
      vecs[19] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h404, 1'b0, 32'h000};
      vecs[20] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h408, 1'b1, 32'h404};

      // Wrap-around instance, first four vectors only: addr valid pc pc_plus4
      wvecs[0] = '{32'hFFFF_FFF8, 1'b0, 32'h0,         32'h0};
      wvecs[1] = '{32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFC};
      wvecs[2] = '{32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000};
      wvecs[3] = '{32'h0000_0004, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000};

      repeat (2) @(posedge clk);
      #1;
      check("rst_req", {31'h0, req0}, 32'h0);
      check("rst_addr", addr0, 32'h0);
      check("rst_valid", {31'h0, v0}, 32'h0);
      check("rst_instr", instr0, 32'h0);
      check("rst_pc", pc0, 32'h0);
      check("rst_pc4", pc4_0, 32'h0);
      check("rst_addr_wrap", addr1, 32'hFFFF_FFF8);
      rst_n = 1'b1;

      for (int i = 0; i < 21; i++) begin
         ack   = vecs[i].ack;
         stall = vecs[i].stall;
         redir = vecs[i].redir;
         rpc   = vecs[i].rpc;
         @(posedge clk);
         #1;
         $display("vec %0d: ack=%b stall=%b redir=%b req=%b addr=%h valid=%b pc=%h",
                  i, ack, stall, redir, req0, addr0, v0, pc0);
         check($sformatf("v%0d_req", i), {31'h0, req0}, {31'h0, vecs[i].e_req});
         check($sformatf("v%0d_addr", i), addr0, vecs[i].e_addr);
         check($sformatf("v%0d_valid", i), {31'h0, v0}, {31'h0, vecs[i].e_valid});
         if (vecs[i].e_valid) begin
            check($sformatf("v%0d_pc", i), pc0, vecs[i].e_pc);
            check($sformatf("v%0d_pc4", i), pc4_0, vecs[i].e_pc + 32'd4);
            check($sformatf("v%0d_instr", i), instr0, vecs[i].e_pc ^ 32'hA5A5_0000);
         end
         if (i < 4) begin
            check($sformatf("w%0d_addr", i), addr1, wvecs[i].e_addr);
            check($sformatf("w%0d_valid", i), {31'h0, v1}, {31'h0, wvecs[i].e_valid});
            if (wvecs[i].e_valid) begin
               check($sformatf("w%0d_pc", i), pc1, wvecs[i].e_pc);
               check($sformatf("w%0d_pc4", i), pc4_1, wvecs[i].e_pc4);
            end
         end
      end

      // Enter HOLD with a buffered instruction, then reset asynchronously mid-cycle
      ack = 1'b1; stall = 1'b1; redir = 1'b0; rpc = 32'h0;
      @(posedge clk);
      #1;
      $display("hold: req=%b addr=%h valid=%b pc=%h", req0, addr0, v0, pc0);
      check("hold_req", {31'h0, req0}, 32'h0);
      check("hold_pc", pc0, 32'h404);
      #2;
      rst_n = 1'b0;
      #1;
      $display("async reset: req=%b addr=%h valid=%b pc=%h", req0, addr0, v0, pc0);
      check("arst_req", {31'h0, req0}, 32'h0);
      check("arst_addr", addr0, 32'h0);
      check("arst_valid", {31'h0, v0}, 32'h0);
      check("arst_instr", instr0, 32'h0);
      check("arst_pc", pc0, 32'h0);
      check("arst_pc4", pc4_0, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      stall = 1'b0;
      @(posedge clk);
      #1;
      $display("restart: req=%b addr=%h valid=%b", req0, addr0, v0);
      check("rs_req", {31'h0, req0}, 32'h1);
      check("rs_addr", addr0, 32'h0);
      check("rs_valid", {31'h0, v0}, 32'h0);
      @(posedge clk);
      #1;
      $display("restart fetch: addr=%h valid=%b pc=%h instr=%h", addr0, v0, pc0, instr0);
      check("rs_valid2", {31'h0, v0}, 32'h1);
      check("rs_pc", pc0, 32'h0);
      check("rs_instr", instr0, 32'hA5A5_0000);
      check("rs_addr2", addr0, 32'h4);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
